matrix_scan_ctrl: RTL and testbench

- Row-scan controller for the 7-row LED matrix decoder. Drives the 3-bit row code (000 = display off, 1..7 = row) and a 5-bit column pattern.
- Accepts 2-out-of-5 digit codes through a valid/ready handshake. Scans the digit's 5x7 glyph row by row, with a blanking gap between rows against ghosting.
- A new code takes effect only at a frame boundary, so no tearing.

---
 rtl/matrix_pkg.sv | 53 +++++
 rtl/glyph_rom.sv | 21 ++
 rtl/matrix_scan_ctrl.sv | 133 +++++++++++++
 tb/tb_matrix_scan_ctrl.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/matrix_pkg.sv
// Shared types, glyph font and 2-out-of-5 decoder for the LED matrix row-scan controller.
package matrix_pkg;

    localparam int unsigned ROWS       = 7;
    localparam int unsigned COLS       = 5;
    localparam int unsigned NUM_GLYPHS = 12;

    typedef enum logic [0:0] {
        ST_BLANK = 1'b0,
        ST_ROW   = 1'b1
    } state_e;

    typedef enum logic [3:0] {
        G_D0, G_D1, G_D2, G_D3, G_D4, G_D5, G_D6, G_D7, G_D8, G_D9,
        G_ERR, G_NONE
    } glyph_e;

    // Row 1 (top) first, bit 4 = leftmost column.
    localparam logic [COLS-1:0] GLYPH_TAB [NUM_GLYPHS][ROWS] = '{
        '{5'b01110, 5'b10001, 5'b10011, 5'b10101, 5'b11001, 5'b10001, 5'b01110},
        '{5'b00100, 5'b01100, 5'b00100, 5'b00100, 5'b00100, 5'b00100, 5'b01110},
        '{5'b01110, 5'b10001, 5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b11111},
        '{5'b11111, 5'b00010, 5'b00100, 5'b00010, 5'b00001, 5'b10001, 5'b01110},
        '{5'b00010, 5'b00110, 5'b01010, 5'b10010, 5'b11111, 5'b00010, 5'b00010},
        '{5'b11111, 5'b10000, 5'b11110, 5'b00001, 5'b00001, 5'b10001, 5'b01110},
        '{5'b00110, 5'b01000, 5'b10000, 5'b11110, 5'b10001, 5'b10001, 5'b01110},
        '{5'b11111, 5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b01000, 5'b01000},
        '{5'b01110, 5'b10001, 5'b10001, 5'b01110, 5'b10001, 5'b10001, 5'b01110},
        '{5'b01110, 5'b10001, 5'b10001, 5'b01111, 5'b00001, 5'b00010, 5'b01100},
        '{5'b11111, 5'b10000, 5'b10000, 5'b11110, 5'b10000, 5'b10000, 5'b11111},
        '{5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000}
    };

    // Weights 7-4-2-1-0; 7+4 encodes digit 0. Anything else is not a legal word.
    function automatic glyph_e two_of_five_decode(input logic [4:0] code);
        glyph_e g;
        case (code)
            5'b00011: g = G_D1;
            5'b00101: g = G_D2;
            5'b00110: g = G_D3;
            5'b01001: g = G_D4;
            5'b01010: g = G_D5;
            5'b01100: g = G_D6;
            5'b10001: g = G_D7;
            5'b10010: g = G_D8;
            5'b10100: g = G_D9;
            5'b11000: g = G_D0;
            default:  g = G_ERR;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/glyph_rom.sv
// Combinational font lookup: glyph index and row 1..7 to a 5-bit column pattern.
module glyph_rom
    import matrix_pkg::*;
(
    input  logic [3:0]      i_glyph,
    input  logic [2:0]      i_row,
    output logic [COLS-1:0] o_col_c
);

    logic [2:0] w_row_idx;

    assign w_row_idx = i_row - 3'd1;

    always_comb begin
        o_col_c = '0;
        if ((i_glyph < 4'(NUM_GLYPHS)) && (i_row != 3'd0)) begin
            o_col_c = GLYPH_TAB[i_glyph][w_row_idx];
        end
    end

endmodule

// File: rtl/matrix_scan_ctrl.sv
// Row-scan controller: blank/dwell per row, one-entry code buffer swapped in only at frame start.
module matrix_scan_ctrl
    import matrix_pkg::*;
#(
    parameter int unsigned DWELL_CYCLES = 1000,
    parameter int unsigned BLANK_CYCLES = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [4:0]      code_in,
    input  logic            code_valid,
    output logic            code_ready,
    output logic [2:0]      row_sel,
    output logic [COLS-1:0] col,
    output logic            frame_start,
    output logic            code_err
);

    localparam int unsigned CNT_MAX    = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int unsigned CNT_W      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic        SKIP_BLANK = (BLANK_CYCLES == 0);

    state_e            r_state;
    logic [2:0]        r_row;
    logic [CNT_W-1:0]  r_cnt;
    glyph_e            r_active;
    glyph_e            r_pend_glyph;
    logic              r_pend_full;
    logic              r_ready;
    logic [2:0]        r_row_sel;
    logic [COLS-1:0]   r_col;
    logic              r_frame_start;
    logic              r_code_err;

    state_e            w_state_next;
    logic [2:0]        w_row_next;
    logic [CNT_W-1:0]  w_cnt_next;
    glyph_e            w_active_next;
    glyph_e            w_pend_glyph_next;
    logic              w_pend_full_next;
    logic              w_in_row;
    logic              w_boundary;
    logic              w_hs;
    logic [COLS-1:0]   w_rom_col;

    // With no blanking the reset BLANK state is treated as row 1's dwell.
    assign w_in_row   = (r_state == ST_ROW) || SKIP_BLANK;
    assign w_boundary = (r_row == 3'd1) && (r_cnt == '0) && ((r_state == ST_BLANK) || SKIP_BLANK);
    assign w_hs       = code_valid && r_ready;

    glyph_rom u_glyph_rom (
        .i_glyph (w_active_next),
        .i_row   (r_row),
        .o_col_c (w_rom_col)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_BLANK;
            r_row         <= 3'd1;
            r_cnt         <= '0;
            r_active      <= G_NONE;
            r_pend_glyph  <= G_NONE;
            r_pend_full   <= 1'b0;
            r_ready       <= 1'b1;
            r_row_sel     <= 3'd0;
            r_col         <= '0;
            r_frame_start <= 1'b0;
            r_code_err    <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_row         <= w_row_next;
            r_cnt         <= w_cnt_next;
            r_active      <= w_active_next;
            r_pend_glyph  <= w_pend_glyph_next;
            r_pend_full   <= w_pend_full_next;
            r_ready       <= !w_pend_full_next;
            r_row_sel     <= w_in_row ? r_row : 3'd0;
            r_col         <= w_in_row ? w_rom_col : '0;
            r_frame_start <= w_boundary;
            r_code_err    <= (w_active_next == G_ERR);
        end
    end

    // Scan sequencing: BLANK_CYCLES of blank, then DWELL_CYCLES lit, rows 1..7.
    always_comb begin
        w_state_next = r_state;
        w_row_next   = r_row;
        w_cnt_next   = r_cnt;
        if (w_in_row) begin
            if (r_cnt == CNT_W'(DWELL_CYCLES - 1)) begin
                w_cnt_next   = '0;
                w_row_next   = (r_row == 3'd7) ? 3'd1 : r_row + 3'd1;
                w_state_next = SKIP_BLANK ? ST_ROW : ST_BLANK;
            end else begin
                w_cnt_next   = r_cnt + CNT_W'(1);
                w_state_next = ST_ROW;
            end
        end else begin
            if (r_cnt == CNT_W'(BLANK_CYCLES - 1)) begin
                w_cnt_next   = '0;
                w_state_next = ST_ROW;
            end else begin
                w_cnt_next   = r_cnt + CNT_W'(1);
            end
        end
    end

    // Code buffering: the displayed glyph changes only on the frame-boundary cycle.
    always_comb begin
        w_active_next     = r_active;
        w_pend_glyph_next = r_pend_glyph;
        w_pend_full_next  = r_pend_full;
        if (w_boundary) begin
            if (r_pend_full) begin
                w_active_next    = r_pend_glyph;
                w_pend_full_next = 1'b0;
            end else if (w_hs) begin
                w_active_next = two_of_five_decode(code_in);
            end
        end else if (w_hs) begin
            w_pend_full_next  = 1'b1;
            w_pend_glyph_next = two_of_five_decode(code_in);
        end
    end

    assign code_ready  = r_ready;
    assign row_sel     = r_row_sel;
    assign col         = r_col;
    assign frame_start = r_frame_start;
    assign code_err    = r_code_err;

endmodule

// File: tb/tb_matrix_scan_ctrl.sv
// Bench for matrix_scan_ctrl: two configurations checked every cycle against a frame-position model.
module tb_matrix_scan_ctrl;

    typedef struct {
        int         t;
        bit         pend;
        int         pend_g;
        int         act;
        bit         rdy;
        bit         hs_last;
        logic [2:0] row;
        logic [4:0] col;
        bit         fs;
        bit         err;
    } model_t;

    typedef struct {
        logic [4:0] code;
        logic       err;
        logic [4:0] r1;
        logic [4:0] r4;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       chk_en = 1'b0;
    logic [4:0] code_a = '0, code_b = '0;
    logic       valid_a = 1'b0, valid_b = 1'b0;
    logic       ready_a, ready_b, fs_a, fs_b, err_a, err_b;
    logic [2:0] row_a, row_b;
    logic [4:0] col_a, col_b;
    int         pass_cnt = 0;
    int         tot_cnt = 0;
    model_t     ma, mb;
    vec_t       vecs[14];

    always #5 clk = ~clk;

    matrix_scan_ctrl #(.DWELL_CYCLES(3), .BLANK_CYCLES(1)) dut_a (
        .clk(clk), .rst(rst), .code_in(code_a), .code_valid(valid_a), .code_ready(ready_a),
        .row_sel(row_a), .col(col_a), .frame_start(fs_a), .code_err(err_a)
    );

    matrix_scan_ctrl #(.DWELL_CYCLES(1), .BLANK_CYCLES(0)) dut_b (
        .clk(clk), .rst(rst), .code_in(code_b), .code_valid(valid_b), .code_ready(ready_b),
        .row_sel(row_b), .col(col_b), .frame_start(fs_b), .code_err(err_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tot_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic fail_timeout(input string name);
        tot_cnt++;
        $display("FAIL %s: timed out waiting, expected event did not occur", name);
    endtask

    function automatic int ref_digit(input logic [4:0] c);
        int s;
        if ($countones(c) != 2) return 10;
        s = 7 * int'(c[4]) + 4 * int'(c[3]) + 2 * int'(c[2]) + int'(c[1]);
        return (s == 11) ? 0 : s;
    endfunction

    function automatic logic [4:0] font_row(input int g, input int r);
        logic [34:0] v;
        case (g)
            0:  v = 35'b01110_10001_10011_10101_11001_10001_01110;
            1:  v = 35'b00100_01100_00100_00100_00100_00100_01110;
            2:  v = 35'b01110_10001_00001_00010_00100_01000_11111;
            3:  v = 35'b11111_00010_00100_00010_00001_10001_01110;
            4:  v = 35'b00010_00110_01010_10010_11111_00010_00010;
            5:  v = 35'b11111_10000_11110_00001_00001_10001_01110;
            6:  v = 35'b00110_01000_10000_11110_10001_10001_01110;
            7:  v = 35'b11111_00001_00010_00100_01000_01000_01000;
            8:  v = 35'b01110_10001_10001_01110_10001_10001_01110;
            9:  v = 35'b01110_10001_10001_01111_00001_00010_01100;
            10: v = 35'b11111_10000_10000_11110_10000_10000_11111;
            default: v = '0;
        endcase
        return v[34 - 5 * (r - 1) -: 5];
    endfunction

    function automatic logic [4:0] rand_code();
        logic [4:0] c;
        c = 5'($urandom);
        if ($urandom_range(0, 3) != 0) begin
            while ($countones(c) != 2) c = 5'($urandom);
        end
        return c;
    endfunction

    task automatic model_reset(inout model_t m);
        m.t = 0; m.pend = 0; m.pend_g = 11; m.act = 11; m.rdy = 1; m.hs_last = 0;
        m.row = '0; m.col = '0; m.fs = 0; m.err = 0;
    endtask

    // One clock edge: position within the frame decides row, phase and whether the code swaps.
    task automatic model_step(input int b, input int d, input logic v, input logic [4:0] c, inout model_t m);
        int  q, row, ph;
        bit  hs, lit;
        q  = m.t % (7 * (b + d));
        hs = v && m.rdy;
        if (q == 0) begin
            if (m.pend) begin
                m.act  = m.pend_g;
                m.pend = 0;
            end else if (hs) begin
                m.act = ref_digit(c);
            end
        end else if (hs) begin
            m.pend   = 1;
            m.pend_g = ref_digit(c);
        end
        m.hs_last = hs;
        m.rdy     = !m.pend;
        row   = q / (b + d) + 1;
        ph    = q % (b + d);
        lit   = (ph >= b);
        m.row = lit ? 3'(row) : 3'd0;
        m.col = lit ? font_row(m.act, row) : 5'd0;
        m.fs  = (q == 0);
        m.err = (m.act == 10);
        m.t++;
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            model_reset(ma);
            model_reset(mb);
        end else begin
            model_step(1, 3, valid_a, code_a, ma);
            model_step(0, 1, valid_b, code_b, mb);
        end
    end

    always @(negedge clk) begin
        if (chk_en && !rst) begin
            check("A.row_sel", 32'(row_a), 32'(ma.row));
            check("A.col", 32'(col_a), 32'(ma.col));
            check("A.frame_start", 32'(fs_a), 32'(ma.fs));
            check("A.code_err", 32'(err_a), 32'(ma.err));
            check("A.code_ready", 32'(ready_a), 32'(ma.rdy));
            check("B.row_sel", 32'(row_b), 32'(mb.row));
            check("B.col", 32'(col_b), 32'(mb.col));
            check("B.frame_start", 32'(fs_b), 32'(mb.fs));
            check("B.code_err", 32'(err_b), 32'(mb.err));
            check("B.code_ready", 32'(ready_b), 32'(mb.rdy));
        end
    end

    task automatic check_reset_vals(input string tag, input logic [2:0] r, input logic [4:0] c,
                                    input logic rd, input logic f, input logic e);
        check({tag, ".rst_row_sel"}, 32'(r), 32'd0);
        check({tag, ".rst_col"}, 32'(c), 32'd0);
        check({tag, ".rst_ready"}, 32'(rd), 32'd1);
        check({tag, ".rst_frame_start"}, 32'(f), 32'd0);
        check({tag, ".rst_code_err"}, 32'(e), 32'd0);
    endtask

    task automatic wait_fs_a();
        for (int i = 0; i < 60; i++) begin
            if (fs_a) return;
            @(negedge clk);
        end
        fail_timeout("A.wait_frame_start");
    endtask

    initial begin
        vecs[0]  = '{5'b00011, 1'b0, 5'b00100, 5'b00100};
        vecs[1]  = '{5'b00101, 1'b0, 5'b01110, 5'b00010};
        vecs[2]  = '{5'b00110, 1'b0, 5'b11111, 5'b00010};
        vecs[3]  = '{5'b01001, 1'b0, 5'b00010, 5'b10010};
        vecs[4]  = '{5'b01010, 1'b0, 5'b11111, 5'b00001};
        vecs[5]  = '{5'b01100, 1'b0, 5'b00110, 5'b11110};
        vecs[6]  = '{5'b10001, 1'b0, 5'b11111, 5'b00100};
        vecs[7]  = '{5'b10010, 1'b0, 5'b01110, 5'b01110};
        vecs[8]  = '{5'b10100, 1'b0, 5'b01110, 5'b01111};
        vecs[9]  = '{5'b11000, 1'b0, 5'b01110, 5'b10101};
        vecs[10] = '{5'b00111, 1'b1, 5'b11111, 5'b11110};
        vecs[11] = '{5'b11000, 1'b0, 5'b01110, 5'b10101};
        vecs[12] = '{5'b00000, 1'b1, 5'b11111, 5'b11110};
        vecs[13] = '{5'b11111, 1'b1, 5'b11111, 5'b11110};

        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_vals("A", row_a, col_a, ready_a, fs_a, err_a);
        check_reset_vals("B", row_b, col_b, ready_b, fs_b, err_b);
        rst = 1'b0;
        chk_en = 1'b1;

        // Idle: blank display, rows 1..7 in order, frame_start every frame.
        repeat (60) @(negedge clk);

        // Decode table on the 7-clock-frame instance.
        for (int k = 0; k < 14; k++) begin
            begin : vec_blk
                bit found;
                found = 0;
                for (int i = 0; i < 20 && !ready_b; i++) @(negedge clk);
                code_b  = vecs[k].code;
                valid_b = 1'b1;
                @(negedge clk);
                valid_b = 1'b0;
                for (int i = 0; i < 20; i++) begin
                    if (fs_b) begin
                        found = 1;
                        break;
                    end
                    @(negedge clk);
                end
                if (!found) fail_timeout("B.table_frame_start");
                check("B.table_err", 32'(err_b), 32'(vecs[k].err));
                check("B.table_row1_col", 32'(col_b), 32'(vecs[k].r1));
                repeat (3) @(negedge clk);
                check("B.table_row4_sel", 32'(row_b), 32'd4);
                check("B.table_row4_col", 32'(col_b), 32'(vecs[k].r4));
                @(negedge clk);
            end
        end

        // Back-to-back codes: second one stalls until the boundary.
        wait_fs_a();
        repeat (5) @(negedge clk);
        code_a  = 5'b01001;
        valid_a = 1'b1;
        @(negedge clk);
        code_a = 5'b10100;
        check("A.ready_drop", 32'(ready_a), 32'd0);
        for (int i = 0; i < 40 && !ready_a; i++) @(negedge clk);
        check("A.ready_rise", 32'(ready_a), 32'd1);
        @(negedge clk);
        valid_a = 1'b0;
        repeat (70) @(negedge clk);

        // Async reset in row 5 with a code pending: pending is dropped.
        wait_fs_a();
        code_a  = 5'b00110;
        valid_a = 1'b1;
        @(negedge clk);
        valid_a = 1'b0;
        check("A.pending_ready", 32'(ready_a), 32'd0);
        for (int i = 0; i < 40 && row_a != 3'd5; i++) @(negedge clk);
        check("A.reached_row5", 32'(row_a), 32'd5);
        #2 rst = 1'b1;
        #1 check_reset_vals("A.mid", row_a, col_a, ready_a, fs_a, err_a);
        @(negedge clk);
        rst = 1'b0;
        repeat (60) @(negedge clk);

        // Randomized traffic, source holds code_in while stalled.
        for (int n = 0; n < 2500; n++) begin
            if (!valid_a || ma.hs_last) begin
                valid_a = ($urandom_range(0, 9) == 0);
                code_a  = rand_code();
            end
            if (!valid_b || mb.hs_last) begin
                valid_b = ($urandom_range(0, 2) == 0);
                code_b  = rand_code();
            end
            @(negedge clk);
        end

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule
